// File: rtl/fan_pkg.sv
// fan_pkg: shared definitions for the fan speed controller.
//   - fan_state_t   : speed state encoding (also the o_speed output value)
//   - DEF_*         : default duty cycles and timer constants
//   - duty_lookup() : maps a speed state to its PWM duty
//   - next_speed()  : speed-button sequence OFF->LOW->MID->HIGH->OFF
`timescale 1ns/1ps
package fan_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_MID  = 2'd2,
    ST_HIGH = 2'd3
  } fan_state_t;

  localparam int unsigned DEF_DUTY_LOW   = 30;
  localparam int unsigned DEF_DUTY_MID   = 60;
  localparam int unsigned DEF_DUTY_HIGH  = 90;
  localparam int unsigned DEF_TIMER_STEP = 10;
  localparam int unsigned DEF_TIMER_MAX  = 30;

  function automatic logic [15:0] duty_lookup(input fan_state_t s,
                                              input logic [15:0] duty_low,
                                              input logic [15:0] duty_mid,
                                              input logic [15:0] duty_high);
    logic [15:0] d;
    case (s)
      ST_LOW:  d = duty_low;
      ST_MID:  d = duty_mid;
      ST_HIGH: d = duty_high;
      default: d = 16'd0;
    endcase
    return d;
  endfunction

  function automatic fan_state_t next_speed(input fan_state_t s);
    fan_state_t n;
    case (s)
      ST_OFF:  n = ST_LOW;
      ST_LOW:  n = ST_MID;
      ST_MID:  n = ST_HIGH;
      default: n = ST_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fan_speed_controller_if.sv
// fan_speed_controller_if: button inputs and fan/display outputs of the
// fan speed controller.
//   i_btn_speed/i_btn_timer/i_btn_off : one-cycle button pulses
//   o_pwm                             : fan PWM drive
//   o_speed                           : current speed state (0..3)
//   o_timer_remaining/o_timer_active  : auto-off countdown status
// master = button source / output consumer, slave = controller.
`timescale 1ns/1ps
interface fan_speed_controller_if;
  logic       i_btn_speed;
  logic       i_btn_timer;
  logic       i_btn_off;
  logic       o_pwm;
  logic [1:0] o_speed;
  logic [7:0] o_timer_remaining;
  logic       o_timer_active;

  modport master (
    output i_btn_speed, i_btn_timer, i_btn_off,
    input  o_pwm, o_speed, o_timer_remaining, o_timer_active
  );

  modport slave (
    input  i_btn_speed, i_btn_timer, i_btn_off,
    output o_pwm, o_speed, o_timer_remaining, o_timer_active
  );
endinterface

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: free-running PWM generator.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   duty_i         : duty requested for the current speed
//   force_off_i    : fan is OFF, hold output low immediately
//   pwm_o          : registered PWM output
// The duty is sampled only at the period boundary so a speed change never
// truncates or stretches a pulse mid-period.
`timescale 1ns/1ps
module fan_pwm_gen #(
  parameter int unsigned PWM_PERIOD = 100
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] duty_i,
  input  logic        force_off_i,
  output logic        pwm_o
);

  localparam int unsigned CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    duty_d = wrap ? duty_i : duty_q;
    pwm_d  = !force_off_i && (16'(cnt_q) < duty_q);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/fan_speed_controller.sv
// fan_speed_controller: fan speed FSM with auto-off countdown timer.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus            : buttons in, PWM / speed / timer status out
// Seconds come from a prescaler that only runs while the timer is active,
// producing a one-cycle tick every TICK_DIV cycles.
`timescale 1ns/1ps
module fan_speed_controller
  import fan_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned PWM_PERIOD = 100,
  parameter int unsigned DUTY_LOW   = DEF_DUTY_LOW,
  parameter int unsigned DUTY_MID   = DEF_DUTY_MID,
  parameter int unsigned DUTY_HIGH  = DEF_DUTY_HIGH,
  parameter int unsigned TIMER_STEP = DEF_TIMER_STEP,
  parameter int unsigned TIMER_MAX  = DEF_TIMER_MAX
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  fan_speed_controller_if.slave  bus
);

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [7:0]  STEP8     = 8'(TIMER_STEP);
  localparam logic [7:0]  MAX8      = 8'(TIMER_MAX);

  fan_state_t  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] presc_q, presc_d;
  logic        active_q;
  logic        tick;
  logic [15:0] duty_cur;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tick    = (timer_q != 8'd0) && (presc_q == TICK_LAST);
    presc_d = tick ? 32'd0 : presc_q + 32'd1;

    if (bus.i_btn_off) begin
      state_d = ST_OFF;
    end else if (bus.i_btn_speed) begin
      state_d = next_speed(state_q);
      if (tick) begin
        timer_d = timer_q - 8'd1;
        // expiry overrides the speed advance
        if (timer_q == 8'd1) state_d = ST_OFF;
      end
    end else if (bus.i_btn_timer) begin
      if (state_q != ST_OFF) begin
        // a press beats a coincident tick and restarts a full second
        timer_d = (timer_q >= MAX8) ? 8'd0 : timer_q + STEP8;
        presc_d = 32'd0;
      end
    end else if (tick) begin
      timer_d = timer_q - 8'd1;
      if (timer_q == 8'd1) state_d = ST_OFF;
    end

    if (state_d == ST_OFF) timer_d = 8'd0;
    // prescaler idles at zero whenever the timer is disabled
    if (timer_d == 8'd0) presc_d = 32'd0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_OFF;
      timer_q  <= 8'd0;
      presc_q  <= 32'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      presc_q  <= presc_d;
      active_q <= (timer_d != 8'd0);
    end
  end

  assign duty_cur = duty_lookup(state_q, 16'(DUTY_LOW), 16'(DUTY_MID), 16'(DUTY_HIGH));

  fan_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .duty_i      (duty_cur),
    .force_off_i (state_q == ST_OFF),
    .pwm_o       (bus.o_pwm)
  );

  assign bus.o_speed           = state_q;
  assign bus.o_timer_remaining = timer_q;
  assign bus.o_timer_active    = active_q;

endmodule
